// File: rtl/moving_average_fifo_filter.sv
// Boxcar moving average over the last 2^N pre-scaled 24-bit samples, kept as a running sum.
// Zero latency (q is combinational); write_ready is accepted but never stalls the filter.
module moving_average_fifo_filter #(
    parameter int N = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               read_ready,
    input  logic               write_ready,
    input  logic signed [23:0] d,
    output logic signed [23:0] q
);
    localparam int DEPTH = 1 << N;
    localparam logic [N:0] DEPTH_C = (N+1)'(DEPTH);

    logic signed [23:0] buf_q [DEPTH];
    logic [N-1:0]       wr_ptr_q, wr_ptr_d;
    logic [N-1:0]       rd_ptr_q, rd_ptr_d;
    logic [N:0]         count_q, count_d;
    logic signed [23:0] acc_q, acc_d;

    logic               step;
    logic               full;
    logic signed [23:0] scaled;
    logic signed [23:0] oldest;
    logic               unused_ok;

    assign unused_ok = write_ready;
    assign step      = enable & read_ready;
    assign scaled    = d >>> N;
    assign full      = (count_q == DEPTH_C);
    // Until the window has filled there is nothing to retire from the sum.
    assign oldest    = full ? buf_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        if (step) begin
            acc_d    = scaled - oldest + acc_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (full) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign q = enable ? acc_d : d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end

    // Sample storage needs no reset: entries are only read once the window is full.
    always_ff @(posedge clock) begin
        if (step) begin
            buf_q[wr_ptr_q] <= scaled;
        end
    end
endmodule

// File: tb/tb_moving_average_fifo_filter.sv
// Randomised and directed checks of the moving-average filter against a queue-based window model.
module tb_moving_average_fifo_filter;
    localparam int WIN = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        read_ready = 1'b0;
    logic        write_ready = 1'b0;
    logic [23:0] d = '0;
    logic [23:0] q;

    int checks = 0;
    int errors = 0;
    int hist[$];

    moving_average_fifo_filter #(.N(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .read_ready  (read_ready),
        .write_ready (write_ready),
        .d           (d),
        .q           (q)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%06h) expected %0d (0x%06h)",
                     tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Floor division by the window length, i.e. the pre-scale rounding toward -inf.
    function automatic int scale(input logic [23:0] v);
        int s;
        s = int'($signed(v));
        if (s >= 0) return s / WIN;
        return -((-s + WIN - 1) / WIN);
    endfunction

    function automatic logic [23:0] model_q(input logic en, input logic rr, input logic [23:0] dv);
        int     win[$];
        longint sum;
        if (!en) return dv;
        win = hist;
        if (rr) begin
            win.push_back(scale(dv));
            if (win.size() > WIN) void'(win.pop_front());
        end
        sum = 0;
        foreach (win[i]) sum += win[i];
        return sum[23:0];
    endfunction

    task automatic do_cycle(input logic en, input logic rr, input logic [23:0] dv, input string tag);
        @(negedge clock);
        enable      = en;
        read_ready  = rr;
        d           = dv;
        write_ready = 1'($urandom);
        #1;
        check_val(tag, q, model_q(en, rr, dv));
        @(posedge clock);
        if (en && rr) begin
            hist.push_back(scale(dv));
            if (hist.size() > WIN) void'(hist.pop_front());
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        hist.delete();
        #1;
        enable = 1'b1;
        read_ready = 1'b0;
        #1;
        check_val("reset_acc", q, 24'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [23:0] v;
        #2;
        enable = 1'b1;
        #1;
        check_val("reset_state", q, 24'd0);
        @(negedge clock);
        reset = 1'b0;

        // Bypass: state must stay frozen.
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'($urandom), 24'd1234, "bypass");
            check_val("bypass_const", q, 24'd1234);
        end
        do_cycle(1'b1, 1'b0, 24'd77, "bypass_acc_held");
        check_val("bypass_acc_zero", q, 24'd0);

        // Warm-up and steady state with constant 200.
        for (int i = 0; i < 12; i++) begin
            do_cycle(1'b1, 1'b1, 24'd200, "warm");
            check_val("warm_const", q, (i < 8) ? 24'(25 * (i + 1)) : 24'd200);
        end

        // Window slide to -8.
        v = -24'sd8;
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b1, 1'b1, v, "slide");
            check_val("slide_const", q, 24'(200 - 26 * (i + 1)));
        end

        // Stall mid warm-up.
        pulse_reset();
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 24'd200, "stall_pre");
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 1'b0, 24'($urandom), "stall_hold");
            check_val("stall_hold_const", q, 24'd75);
        end
        do_cycle(1'b1, 1'b1, 24'd200, "stall_resume");
        check_val("stall_resume_const", q, 24'd100);

        // Async reset with a full window.
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b1, 24'd200, "refill");
        pulse_reset();
        do_cycle(1'b1, 1'b1, 24'd200, "post_reset");
        check_val("post_reset_const", q, 24'd25);
        do_cycle(1'b1, 1'b1, 24'd200, "post_reset2");
        check_val("post_reset2_const", q, 24'd50);

        // Random traffic, including disable/re-enable with retained history.
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 7) != 0), 1'($urandom), 24'($urandom), "random");
            if (i == 200) pulse_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/moving_average_fifo_filter.md
Name: moving_average_fifo_filter

Overview:
- Streaming 24-bit signed moving-average (boxcar FIR) filter over the last 2^N samples.
- Sits in the audio path between a sample source (`read_ready` strobe) and a sink.
- Uses a running-sum architecture with two internal parts:
  - a circular sample buffer (FIFO) of depth 2^N holding pre-scaled samples;
  - an accumulator register.
- When disabled, input passes straight through to the output.

Parameters:
- N, 3, log2 of window length; buffer depth = 2^N entries; sample pre-scale = arithmetic right shift by N.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears buffer and accumulator
- enable  input  1  filter enable; 0 = bypass and freeze state
- read_ready  input  1  new input sample valid strobe; one filter step per cycle it is high with enable
- write_ready  input  1  downstream ready; accepted but ignored (no effect on behaviour)
- d  input  24  signed input sample
- q  output  24  signed filtered output (combinational)

Behaviour:
- Reset (async, active-high):
  - accumulator = 0;
  - buffer write pointer = 0, read pointer = 0, count = 0 (empty, not full);
  - buffer contents don't-care.
- Derived signals:
  - step = enable & read_ready;
  - scaled = d >>> N (arithmetic shift, rounds toward -inf; e.g. 200→25, -8→-1, -1→-1);
  - full = (count == 2^N);
  - oldest = buffer entry at read pointer (combinational read), forced to 0 when not full.
- Next accumulator value: acc_next = step ? (scaled - oldest + acc) : acc. All 24-bit signed two's-complement, wrap on overflow, no saturation.
- Output q = enable ? acc_next : d (combinational, zero latency). The current sample is included in the same cycle it is presented.
- On a rising edge with step=1:
  - write scaled at the write pointer, then advance the write pointer modulo 2^N;
  - if full, also pop: advance the read pointer modulo 2^N, and count stays 2^N;
  - if not full, count increments;
  - acc <= acc_next.
- On a rising edge with step=0: no buffer or pointer change; acc holds.
- Simultaneous read/write when full: the read returns the old entry, then the slot is overwritten with the new sample in the same edge.
- Buffer never reads when empty and never writes when full without a simultaneous read; no overflow or underflow possible.
- Warm-up: for the first 2^N steps after reset the output is a partial sum of the scaled samples.
- Windowed phase: from step 2^N onward, q is the sum of the last 2^N scaled samples.
- enable=1, read_ready=0: q = current acc (held).
- enable deasserted then reasserted: history is retained, not flushed.
- Reset mid-operation clears everything immediately; the next step restarts warm-up.

Test Plan:
- Reset, then enable=0, d=1234 -> q=1234 (bypass); acc unchanged after several edges.
- N=3, reset, then enable=1, read_ready=1, d=200 constant:
  - steps 0..7 -> q = 25, 50, 75, …, 200;
  - from step 8 on -> q=200 steady;
  - full asserts after 8th edge.
- Window slide:
  - fill 8 steps with d=200 (q=200);
  - then d=-8 for 8 steps -> q = 200-25-1 = 174, then 148, … decreasing by 26 per step, ending at -8.
- Stall: mid-warm-up (after 3 steps, acc=75) drop read_ready for 5 cycles -> q holds 75, count stays 3; resume -> next q=100.
- Async reset mid-run (window full, acc=200): assert reset between edges -> acc=0 immediately, q=d>>>3 on next enabled step (25 for d=200), warm-up repeats.
- write_ready toggled randomly during the constant-200 sequence -> identical q sequence.
